m68k_bus_ctrl: RTL and testbench

M68K_BUS_CTRL -- requirements
Module: m68k_bus_ctrl

---
 rtl/m68k_bus_pkg.sv | 32 +++
 rtl/m68k_bus_ctrl_if.sv | 37 +++
 rtl/m68k_addr_match.sv | 36 +++
 rtl/m68k_bus_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_m68k_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/m68k_bus_pkg.sv
// -----------------------------------------------------------------------------
// m68k_bus_pkg
// Shared definitions for the 68000 bus controller:
//   - FSM state encoding (legacy-compatible localparam constants)
//   - widths of the region index and the shared wait/timeout counter
//   - default chip-select region tables (region 0 is the left-most field)
//   - helper that converts a bus-error timeout into a counter load value
// -----------------------------------------------------------------------------
package m68k_bus_pkg;

    localparam int CS_IDX_W = 3;
    localparam int CNT_W    = 10;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_ACK  = 3'd2;
    localparam logic [2:0] ST_MISS = 3'd3;
    localparam logic [2:0] ST_BERR = 3'd4;

    // Tables are packed with region 0 in the most significant field, so the
    // literal reads left to right as region 0, 1, 2, 3.
    localparam logic [43:0] DEF_REGION_BASE = {11'h000, 11'h100, 11'h400, 11'h7FF};
    localparam logic [43:0] DEF_REGION_MASK = {11'h700, 11'h700, 11'h600, 11'h7FF};
    localparam logic [15:0] DEF_WAIT_STATES = {4'd1, 4'd0, 4'd2, 4'd3};

    // The miss counter is loaded with cycles-1 and counts down to 0, so BERR
    // lands exactly 'cycles' clocks after the MISS state is entered.
    function automatic logic [CNT_W-1:0] berr_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/m68k_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// m68k_bus_ctrl_if
// 68000-side bus bundle between the CPU (master) and the bus controller (slave).
//   as_n, uds_n, lds_n, rw : CPU strobes (asynchronous to clk50)
//   addr                   : A23..A13, stable while as_n is low
//   cs_n                   : active-low chip selects
//   oe_n, we_uds_n, we_lds_n : read enable and per-lane write enables
//   dtack_n, berr_n        : cycle terminations
//   busy                   : controller is inside a bus cycle
// -----------------------------------------------------------------------------
interface m68k_bus_ctrl_if #(
    parameter int NUM_CS = 4,
    parameter int AW     = 11
);
    logic              as_n;
    logic              uds_n;
    logic              lds_n;
    logic              rw;
    logic [AW-1:0]     addr;
    logic [NUM_CS-1:0] cs_n;
    logic              oe_n;
    logic              we_uds_n;
    logic              we_lds_n;
    logic              dtack_n;
    logic              berr_n;
    logic              busy;

    modport master (
        output as_n, uds_n, lds_n, rw, addr,
        input  cs_n, oe_n, we_uds_n, we_lds_n, dtack_n, berr_n, busy
    );

    modport slave (
        input  as_n, uds_n, lds_n, rw, addr,
        output cs_n, oe_n, we_uds_n, we_lds_n, dtack_n, berr_n, busy
    );
endinterface

// File: rtl/m68k_addr_match.sv
// -----------------------------------------------------------------------------
// m68k_addr_match
// Combinational chip-select region decoder.
//   addr : decoded address bits A23..A13
//   hit  : some region matched
//   idx  : index of the matching region, lowest index wins on overlap
// Region i matches when ((addr ^ BASE[i]) & MASK[i]) == 0.
// -----------------------------------------------------------------------------
module m68k_addr_match
    import m68k_bus_pkg::*;
#(
    parameter int                   NUM_CS      = 4,
    parameter int                   AW          = 11,
    parameter logic [NUM_CS*AW-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_CS*AW-1:0] REGION_MASK = DEF_REGION_MASK
) (
    input  logic [AW-1:0]       addr,
    output logic                hit,
    output logic [CS_IDX_W-1:0] idx
);

    // Scan from the highest region down so the lowest matching index is the
    // last assignment and therefore has priority.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if (((addr ^ REGION_BASE[(NUM_CS-1-i)*AW +: AW])
                 & REGION_MASK[(NUM_CS-1-i)*AW +: AW]) == '0) begin
                hit = 1'b1;
                idx = CS_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/m68k_bus_ctrl.sv
// -----------------------------------------------------------------------------
// m68k_bus_ctrl
// 68000 bus controller: chip-select decode, wait-state insertion, DTACK/BERR
// generation and a boot overlay that maps every access to BOOT_CS for the
// first BOOT_CYCLES terminated bus cycles after reset.
//   clk50 : system clock, all state on its rising edge
//   rst_n : asynchronous active-low reset
//   boot  : enables the boot overlay (captured while reset is asserted)
//   bus   : 68000 bus bundle, slave side
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module m68k_bus_ctrl
    import m68k_bus_pkg::*;
#(
    parameter int                   NUM_CS      = 4,
    parameter int                   AW          = 11,
    parameter logic [NUM_CS*AW-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_CS*AW-1:0] REGION_MASK = DEF_REGION_MASK,
    parameter logic [NUM_CS*4-1:0]  WAIT_STATES = DEF_WAIT_STATES,
    parameter int                   BERR_CYCLES = 64,
    parameter int                   BOOT_CS     = 0,
    parameter int                   BOOT_CYCLES = 4
) (
    input  logic           clk50,
    input  logic           rst_n,
    input  logic           boot,
    m68k_bus_ctrl_if.slave bus
);

    logic as_meta_q, as_s_q, as_prev_q;
    logic uds_meta_q, uds_s_q;
    logic lds_meta_q, lds_s_q;
    logic rw_meta_q, rw_s_q;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CS_IDX_W-1:0] idx_q, idx_d;
    logic                rw_lat_q, rw_lat_d;
    logic                ovl_flag_q, ovl_flag_d;
    logic [3:0]          ovl_cnt_q, ovl_cnt_d;

    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic oe_n_q, oe_n_d;
    logic we_uds_n_q, we_uds_n_d;
    logic we_lds_n_q, we_lds_n_d;
    logic dtack_n_q, dtack_n_d;
    logic berr_n_q, berr_n_d;
    logic busy_q, busy_d;

    logic                match_hit;
    logic [CS_IDX_W-1:0] match_idx;
    logic                dec_hit;
    logic [CS_IDX_W-1:0] dec_idx;
    logic [3:0]          ws_sel;
    logic                as_fall;
    logic                term_done;
    logic                cs_active_d;

    m68k_addr_match #(
        .NUM_CS      (NUM_CS),
        .AW          (AW),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_match (
        .addr (bus.addr),
        .hit  (match_hit),
        .idx  (match_idx)
    );

    // Two-flop synchronizers for the asynchronous strobes. They idle high so
    // that a strobe already low at reset release still produces a clean edge.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            as_meta_q  <= 1'b1;
            as_s_q     <= 1'b1;
            as_prev_q  <= 1'b1;
            uds_meta_q <= 1'b1;
            uds_s_q    <= 1'b1;
            lds_meta_q <= 1'b1;
            lds_s_q    <= 1'b1;
            rw_meta_q  <= 1'b1;
            rw_s_q     <= 1'b1;
        end else begin
            as_meta_q  <= bus.as_n;
            as_s_q     <= as_meta_q;
            as_prev_q  <= as_s_q;
            uds_meta_q <= bus.uds_n;
            uds_s_q    <= uds_meta_q;
            lds_meta_q <= bus.lds_n;
            lds_s_q    <= lds_meta_q;
            rw_meta_q  <= bus.rw;
            rw_s_q     <= rw_meta_q;
        end
    end

    assign as_fall = as_prev_q & ~as_s_q;

    // The overlay overrides the decoder completely, even for unmapped addresses.
    always_comb begin
        dec_hit = match_hit | ovl_flag_q;
        dec_idx = ovl_flag_q ? CS_IDX_W'(BOOT_CS) : match_idx;
        ws_sel  = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (dec_idx == CS_IDX_W'(i)) begin
                ws_sel = WAIT_STATES[(NUM_CS-1-i)*4 +: 4];
            end
        end
    end

    // Cycle FSM. The decode result and rw are captured at cycle start, so the
    // address itself does not need to be held. Only cycles that end in DTACK
    // or BERR advance the overlay; aborted cycles leave it untouched.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rw_lat_d   = rw_lat_q;
        ovl_flag_d = ovl_flag_q;
        ovl_cnt_d  = ovl_cnt_q;
        term_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (as_fall) begin
                    rw_lat_d = rw_s_q;
                    if (dec_hit) begin
                        state_d = ST_WAIT;
                        idx_d   = dec_idx;
                        cnt_d   = CNT_W'(ws_sel);
                    end else begin
                        state_d = ST_MISS;
                        cnt_d   = berr_load(BERR_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (as_s_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                if (as_s_q) begin
                    state_d   = ST_IDLE;
                    term_done = 1'b1;
                end
            end
            ST_MISS: begin
                if (as_s_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_BERR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_BERR: begin
                if (as_s_q) begin
                    state_d   = ST_IDLE;
                    term_done = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (term_done && ovl_flag_q) begin
            if (ovl_cnt_q <= 4'd1) begin
                ovl_cnt_d  = 4'd0;
                ovl_flag_d = 1'b0;
            end else begin
                ovl_cnt_d = ovl_cnt_q - 4'd1;
            end
        end
    end

    // Outputs are derived from the next state so the registered versions line
    // up with the state they belong to, with no extra cycle of latency.
    always_comb begin
        cs_active_d = (state_d == ST_WAIT) || (state_d == ST_ACK);
        for (int i = 0; i < NUM_CS; i++) begin
            cs_n_d[i] = !(cs_active_d && (idx_d == CS_IDX_W'(i)));
        end
        oe_n_d     = !(cs_active_d && rw_lat_d);
        we_uds_n_d = !(cs_active_d && !rw_lat_d && !uds_s_q);
        we_lds_n_d = !(cs_active_d && !rw_lat_d && !lds_s_q);
        dtack_n_d  = !(state_d == ST_ACK);
        berr_n_d   = !(state_d == ST_BERR);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers; reset forces every output inactive at once.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            rw_lat_q   <= 1'b1;
            ovl_flag_q <= boot;
            ovl_cnt_q  <= 4'(BOOT_CYCLES);
            cs_n_q     <= '1;
            oe_n_q     <= 1'b1;
            we_uds_n_q <= 1'b1;
            we_lds_n_q <= 1'b1;
            dtack_n_q  <= 1'b1;
            berr_n_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rw_lat_q   <= rw_lat_d;
            ovl_flag_q <= ovl_flag_d;
            ovl_cnt_q  <= ovl_cnt_d;
            cs_n_q     <= cs_n_d;
            oe_n_q     <= oe_n_d;
            we_uds_n_q <= we_uds_n_d;
            we_lds_n_q <= we_lds_n_d;
            dtack_n_q  <= dtack_n_d;
            berr_n_q   <= berr_n_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.cs_n     = cs_n_q;
    assign bus.oe_n     = oe_n_q;
    assign bus.we_uds_n = we_uds_n_q;
    assign bus.we_lds_n = we_lds_n_q;
    assign bus.dtack_n  = dtack_n_q;
    assign bus.berr_n   = berr_n_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_m68k_bus_ctrl
// Directed bus cycles against the default-parameter controller. Each cycle
// pushes its expected chip select, enables, termination kind and latency into
// a queue; an independent monitor pops and compares when the DUT terminates
// or abandons a cycle.
// -----------------------------------------------------------------------------
module tb_m68k_bus_ctrl;

    localparam int KIND_DTACK = 0;
    localparam int KIND_BERR  = 1;
    localparam int KIND_ABORT = 2;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_SHORT  = 1;
    localparam int MODE_WAIT   = 2;

    typedef struct {
        logic [3:0] csN;
        logic       oeN;
        logic       weUdsN;
        logic       weLdsN;
        int         kind;
        int         lat;
    } expT;

    logic clk50 = 1'b0;
    logic rst_n;
    logic boot;

    int totalChecks  = 0;
    int passedChecks = 0;
    expT expQ[$];

    m68k_bus_ctrl_if #(.NUM_CS(4), .AW(11)) bus ();

    m68k_bus_ctrl dut (
        .clk50 (clk50),
        .rst_n (rst_n),
        .boot  (boot),
        .bus   (bus)
    );

    // 50 MHz system clock.
    always #10 clk50 = ~clk50;

    function automatic expT mkExp(input logic [3:0] cs, input logic oe, input logic wu,
                                  input logic wl, input int kind, input int lat);
        expT e;
        e.csN    = cs;
        e.oeN    = oe;
        e.weUdsN = wu;
        e.weLdsN = wl;
        e.kind   = kind;
        e.lat    = lat;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual === expected) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Runs one CPU bus cycle. NORMAL waits for a termination, SHORT pulses AS
    // for a single clock, WAIT negates AS as soon as the controller goes busy.
    task automatic applyStimulus(input logic [10:0] a, input logic r, input logic u,
                                 input logic l, input int mode, input expT e);
        logic seen;
        expQ.push_back(e);
        @(negedge clk50);
        bus.addr = a;
        bus.rw   = r;
        @(negedge clk50);
        bus.as_n  = 1'b0;
        bus.uds_n = u;
        bus.lds_n = l;
        if (mode == MODE_SHORT) begin
            @(negedge clk50);
        end else if (mode == MODE_WAIT) begin
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk50);
                seen = bus.busy;
            end
            checkOutput("busyStartWait", 32'(seen), 32'd1);
        end else begin
            seen = 1'b0;
            for (int n = 0; n < 200 && !seen; n++) begin
                @(negedge clk50);
                seen = !bus.dtack_n || !bus.berr_n;
            end
            checkOutput("terminationWait", 32'(seen), 32'd1);
            @(negedge clk50);
        end
        bus.as_n  = 1'b1;
        bus.uds_n = 1'b1;
        bus.lds_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk50);
            seen = !bus.busy;
        end
        checkOutput("idleReturnWait", 32'(seen), 32'd1);
        repeat (2) @(negedge clk50);
    endtask

    // Monitor: tracks each busy period, measures clocks from cycle start to
    // the termination, and pops the scoreboard on termination or abandonment.
    logic       inCycle  = 1'b0;
    logic       termSeen = 1'b0;
    int         latCount = 0;
    logic [3:0] startCs;
    logic       startOe, startWu, startWl;
    expT        mExp;

    initial begin
        forever begin
            @(negedge clk50);
            if (!inCycle) begin
                if (bus.busy === 1'b1) begin
                    inCycle  = 1'b1;
                    termSeen = 1'b0;
                    latCount = 0;
                    startCs  = bus.cs_n;
                    startOe  = bus.oe_n;
                    startWu  = bus.we_uds_n;
                    startWl  = bus.we_lds_n;
                end
            end else begin
                if (!termSeen) latCount++;
                if (!termSeen && (!bus.dtack_n || !bus.berr_n)) begin
                    termSeen = 1'b1;
                    checkOutput("dtackBerrExclusive", 32'(bus.dtack_n | bus.berr_n), 32'd1);
                    checkOutput("expectedPending", 32'(expQ.size() != 0), 32'd1);
                    if (expQ.size() != 0) begin
                        mExp = expQ.pop_front();
                        checkOutput("csN", 32'(startCs), 32'(mExp.csN));
                        checkOutput("oeN", 32'(startOe), 32'(mExp.oeN));
                        checkOutput("weUdsN", 32'(startWu), 32'(mExp.weUdsN));
                        checkOutput("weLdsN", 32'(startWl), 32'(mExp.weLdsN));
                        checkOutput("termKind", bus.dtack_n ? KIND_BERR : KIND_DTACK, mExp.kind);
                        checkOutput("termLatency", latCount, mExp.lat);
                        checkOutput("csHeldAtTerm", 32'(bus.cs_n), 32'(mExp.csN));
                    end
                end else if (bus.busy !== 1'b1) begin
                    if (!termSeen) begin
                        checkOutput("expectedPending", 32'(expQ.size() != 0), 32'd1);
                        if (expQ.size() != 0) begin
                            mExp = expQ.pop_front();
                            checkOutput("abortCsN", 32'(startCs), 32'(mExp.csN));
                            checkOutput("abortOeN", 32'(startOe), 32'(mExp.oeN));
                            checkOutput("abortKind", KIND_ABORT, mExp.kind);
                        end
                    end
                    checkOutput("releaseDtack", 32'(bus.dtack_n), 32'd1);
                    checkOutput("releaseBerr", 32'(bus.berr_n), 32'd1);
                    checkOutput("releaseCs", 32'(bus.cs_n), 32'hF);
                    inCycle = 1'b0;
                end
            end
        end
    end

    // Watchdog so a stuck DUT still produces a verdict.
    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        logic seen;
        rst_n     = 1'b0;
        boot      = 1'b1;
        bus.as_n  = 1'b1;
        bus.uds_n = 1'b1;
        bus.lds_n = 1'b1;
        bus.rw    = 1'b1;
        bus.addr  = '0;
        repeat (2) @(negedge clk50);
        checkOutput("resetCsN", 32'(bus.cs_n), 32'hF);
        checkOutput("resetOeN", 32'(bus.oe_n), 32'd1);
        checkOutput("resetWeUdsN", 32'(bus.we_uds_n), 32'd1);
        checkOutput("resetWeLdsN", 32'(bus.we_lds_n), 32'd1);
        checkOutput("resetDtackN", 32'(bus.dtack_n), 32'd1);
        checkOutput("resetBerrN", 32'(bus.berr_n), 32'd1);
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk50);

        // Boot overlay: addr 400 is forced onto CS0 (1 wait state) for four
        // terminated cycles; a one-clock aborted cycle must not use one up.
        applyStimulus(11'h400, 1'b1, 1'b0, 1'b0, MODE_NORMAL, mkExp(4'b1110, 1'b0, 1'b1, 1'b1, KIND_DTACK, 2));
        applyStimulus(11'h400, 1'b1, 1'b0, 1'b0, MODE_NORMAL, mkExp(4'b1110, 1'b0, 1'b1, 1'b1, KIND_DTACK, 2));
        applyStimulus(11'h400, 1'b1, 1'b0, 1'b0, MODE_SHORT,  mkExp(4'b1110, 1'b0, 1'b1, 1'b1, KIND_ABORT, 0));
        applyStimulus(11'h400, 1'b1, 1'b0, 1'b0, MODE_NORMAL, mkExp(4'b1110, 1'b0, 1'b1, 1'b1, KIND_DTACK, 2));
        applyStimulus(11'h400, 1'b1, 1'b0, 1'b0, MODE_NORMAL, mkExp(4'b1110, 1'b0, 1'b1, 1'b1, KIND_DTACK, 2));
        applyStimulus(11'h400, 1'b1, 1'b0, 1'b0, MODE_NORMAL, mkExp(4'b1011, 1'b0, 1'b1, 1'b1, KIND_DTACK, 3));

        // Reset without boot: normal decode from the very first cycle.
        rst_n = 1'b0;
        boot  = 1'b0;
        repeat (2) @(negedge clk50);
        rst_n = 1'b1;
        repeat (3) @(negedge clk50);

        applyStimulus(11'h400, 1'b1, 1'b0, 1'b0, MODE_NORMAL, mkExp(4'b1011, 1'b0, 1'b1, 1'b1, KIND_DTACK, 3));
        applyStimulus(11'h101, 1'b1, 1'b0, 1'b0, MODE_NORMAL, mkExp(4'b1101, 1'b0, 1'b1, 1'b1, KIND_DTACK, 1));
        applyStimulus(11'h7FF, 1'b0, 1'b0, 1'b1, MODE_NORMAL, mkExp(4'b0111, 1'b1, 1'b0, 1'b1, KIND_DTACK, 4));
        applyStimulus(11'h0A5, 1'b0, 1'b1, 1'b0, MODE_NORMAL, mkExp(4'b1110, 1'b1, 1'b1, 1'b0, KIND_DTACK, 2));
        applyStimulus(11'h0A5, 1'b1, 1'b0, 1'b0, MODE_NORMAL, mkExp(4'b1110, 1'b0, 1'b1, 1'b1, KIND_DTACK, 2));
        applyStimulus(11'h300, 1'b1, 1'b0, 1'b0, MODE_NORMAL, mkExp(4'b1111, 1'b1, 1'b1, 1'b1, KIND_BERR, 64));
        applyStimulus(11'h7FF, 1'b1, 1'b0, 1'b0, MODE_WAIT,   mkExp(4'b0111, 1'b0, 1'b1, 1'b1, KIND_ABORT, 0));
        applyStimulus(11'h1F0, 1'b1, 1'b0, 1'b0, MODE_NORMAL, mkExp(4'b1101, 1'b0, 1'b1, 1'b1, KIND_DTACK, 1));

        // Reset while DTACK is held: outputs must go inactive without a clock.
        expQ.push_back(mkExp(4'b0111, 1'b0, 1'b1, 1'b1, KIND_DTACK, 4));
        @(negedge clk50);
        bus.addr = 11'h7FF;
        bus.rw   = 1'b1;
        @(negedge clk50);
        bus.as_n = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk50);
            seen = !bus.dtack_n;
        end
        checkOutput("ackReachedBeforeReset", 32'(seen), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midResetDtackN", 32'(bus.dtack_n), 32'd1);
        checkOutput("midResetCsN", 32'(bus.cs_n), 32'hF);
        checkOutput("midResetOeN", 32'(bus.oe_n), 32'd1);
        checkOutput("midResetBusy", 32'(bus.busy), 32'd0);
        bus.as_n = 1'b1;
        repeat (3) @(negedge clk50);
        rst_n = 1'b1;
        repeat (5) @(negedge clk50);
        checkOutput("postResetBusy", 32'(bus.busy), 32'd0);
        checkOutput("postResetCsN", 32'(bus.cs_n), 32'hF);
        checkOutput("postResetDtackN", 32'(bus.dtack_n), 32'd1);

        applyStimulus(11'h101, 1'b1, 1'b0, 1'b0, MODE_NORMAL, mkExp(4'b1101, 1'b0, 1'b1, 1'b1, KIND_DTACK, 1));

        repeat (10) @(negedge clk50);
        checkOutput("scoreboardDrained", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
